// File: rtl/wb_data_queue.sv
// Write-back data selector feeding a DEPTH-entry FIFO that drains into the
// register bank through a valid/ready handshake.
module wb_data_queue #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 8,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic [NSRC*WIDTH-1:0]     i_data_in,
  input  logic                      i_wr_req,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic                      i_wb_ready,
  output logic                      o_wb_valid,
  output logic [ADDR_W-1:0]         o_wb_addr,
  output logic [WIDTH-1:0]          o_wb_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [WIDTH-1:0]  r_mem_data [DEPTH];

  logic [WIDTH-1:0]  w_sel_data;
  logic              w_full;
  logic              w_empty;
  logic              w_req_ok;
  logic              w_deq;
  logic              w_enq;
  logic              w_unused_const_ch;

  // The top channel is replaced by the constant, so its input bits are dead.
  assign w_unused_const_ch = ^i_data_in[NSRC*WIDTH-1 -: WIDTH];

  always_comb begin
    w_sel_data = WIDTH'(CONST_VAL);
    for (int k = 0; k < int'(NSRC) - 1; k++) begin
      if (i_sel == SEL_W'(k)) begin
        w_sel_data = i_data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_deq    = !w_empty && i_wb_ready;
  // Register 0 is hard-wired, so writes to it are never queued.
  assign w_req_ok = i_wr_req && (i_wr_addr != '0);
  assign w_enq    = w_req_ok && (!w_full || w_deq);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_enq && !w_deq) begin
        r_count <= r_count + 1'b1;
      end else if (w_deq && !w_enq) begin
        r_count <= r_count - 1'b1;
      end
      if (w_req_ok && w_full && !w_deq) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_mem_addr[r_wptr] <= i_wr_addr;
      r_mem_data[r_wptr] <= w_sel_data;
    end
  end

  assign o_wb_valid = !w_empty;
  assign o_wb_addr  = w_empty ? '0 : r_mem_addr[r_rptr];
  assign o_wb_data  = w_empty ? '0 : r_mem_data[r_rptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_ovf      = r_ovf;

endmodule

// File: doc/wb_data_queue.md
# wb_data_queue

Parametrised write-back data selector with a buffered write port for the register bank. Each cycle it selects one of NSRC source words (the top channel is a fixed constant), tags it with a destination register number, and enqueues the pair into a DEPTH-entry FIFO. The FIFO drains one write per accepted cycle into the register bank through a valid/ready handshake. It sits between the datapath sources (ALU, memory data register, shifter, LO/HI, PC+4, …) and the register bank write port, replacing the unregistered write-data mux.

## Interface
- WIDTH, 32, data word width
- NSRC, 8, number of selectable channels; channel NSRC-1 is the constant
- SEL_W, 3, selector width; must satisfy 2^SEL_W >= NSRC
- DEPTH, 4, FIFO entries; power of two, >= 2
- ADDR_W, 5, register-number width
- CONST_VAL, 227, value driven on the constant channel
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- sel  in  SEL_W  source select
- data_in  in  NSRC*WIDTH  flattened sources; channel k at bits [k*WIDTH +: WIDTH]; channel NSRC-1 bits ignored
- wr_req  in  1  enqueue request for the selected word
- wr_addr  in  ADDR_W  destination register of the request
- wb_ready  in  1  register bank accepts the head entry this cycle
- wb_valid  out  1  head entry present
- wb_addr  out  ADDR_W  head destination register
- wb_data  out  WIDTH  head data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupancy
- ovf  out  1  sticky overflow flag

## Operation
- Selection (combinational): sel < NSRC-1 → channel sel; sel == NSRC-1 or sel >= NSRC → CONST_VAL zero-extended/truncated to WIDTH.
- Enqueue condition: wr_req && wr_addr != 0 && (!full || deq). Writes to register 0 are dropped silently, never stored, never flag ovf.
- Dequeue condition deq = wb_valid && wb_ready.
- Storage: circular buffer, write pointer and read pointer each $clog2(DEPTH) bits, wrap modulo DEPTH; count tracks occupancy separately (no pointer-compare ambiguity).
- count update: +1 on enqueue only, −1 on dequeue only, unchanged on both or neither.
- Full with simultaneous enqueue and dequeue: both happen, count stays DEPTH, full stays 1.
- Empty with wr_req: entry stored; no same-cycle bypass to the output.
- Overflow: wr_req && wr_addr != 0 && full && !deq → request discarded, ovf set to 1; ovf cleared only by reset.
- wb_valid = !empty; wb_addr/wb_data = entry at read pointer when !empty, else all zeros.
- wb_ready while empty has no effect.
- Reset (asserted at any time, including mid-drain): pointers, count, ovf → 0 asynchronously; outputs become wb_valid=0, wb_addr=0, wb_data=0, full=0, empty=1, count=0, ovf=0. Storage array contents need not be cleared. Pending entries are lost.

## Timing
- Enqueue-to-output latency: 1 cycle; data enqueued at edge N is on wb_data with wb_valid=1 after edge N (visible in cycle N+1).
- Throughput: one enqueue and one dequeue per cycle, sustained, at any occupancy.
- full, empty, count, ovf are registered-state outputs; they reflect edge N results in cycle N+1.
- wb_data/wb_addr are stable while wb_valid=1 and wb_ready=0.
- Release of reset is synchronous to clk by the caller; first enqueue possible on the first rising edge with reset=1.

## Test plan
- Reset then sel=2, data_in ch2=32'h0000_00AA, wr_req=1, wr_addr=5 for one cycle, wb_ready=0 → next cycle wb_valid=1, wb_addr=5, wb_data=32'hAA, count=1.
- sel=7 (NSRC=8) and sel outside range with NSRC=6 → enqueued data = 227 (32'h0000_00E3), regardless of data_in.
- wr_req=1, wr_addr=0 for 3 cycles → count stays 0, ovf=0, wb_valid=0.
- wb_ready=0, enqueue 5 distinct words (DEPTH=4) → full=1 after 4th, 5th discarded, ovf=1; then wb_ready=1 → words 1–4 drained in order, empty=1 after 4 cycles, ovf still 1.
- Fill to full, then wr_req=1 and wb_ready=1 for 8 cycles with incrementing data → count stays 4, ovf stays 0, output order matches input order across pointer wrap.
- With count=3 mid-drain, pull reset low between edges → outputs zero and empty=1 immediately, before next edge; after release, fresh enqueue appears 1 cycle later.
